result_mux_arbiter: RTL and testbench
=====================================

Name: result_mux_arbiter

Overview:
- Shares one 32-bit result path between four requesters (ALU, multiplier/divider, shifter, immediate/load source) in the MIPS calculator datapath.
- Arbitrates with a round-robin or fixed-priority policy and drives the 2-bit select of the 32-bit 4-to-1 result mux.
- Registers the selected word into a single-entry output stage with a valid/ready handshake toward the writeback/display consumer.

Parameters:
DATA_W, 32, width of each requester data word and of out_data
PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority (A highest, D lowest)

Ports:
Clk  input  1  rising-edge clock
Rst_n  input  1  asynchronous active-low reset
req  input  4  request per source; bit0=A, bit1=B, bit2=C, bit3=D
in_a  input  DATA_W  source A data, valid while req[0]=1
in_b  input  DATA_W  source B data, valid while req[1]=1
in_c  input  DATA_W  source C data, valid while req[2]=1
in_d  input  DATA_W  source D data, valid while req[3]=1
gnt  output  4  one-hot combinational grant; the source's word is captured at this clock edge
sel  output  2  mux select for the current winner; same encoding as gnt index
out_valid  output  1  out_data holds an unconsumed word
out_data  output  DATA_W  registered selected word
out_src  output  2  index of the source that produced out_data
out_ready  input  1  consumer accepts out_data when out_valid=1 and out_ready=1

Behaviour:
- Reset (Rst_n low, asynchronous): out_valid=0, out_data=0, out_src=0, state=EMPTY, last_ptr=3 so A wins first. gnt and sel are combinational but forced to 0 while Rst_n is low.
- States:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- can_load = (state==EMPTY) || out_ready.
- Winner selection:
  - Round-robin: the first set req bit scanning last_ptr+1, +2, +3, +4 (mod 4, wrapping 3->0).
  - Fixed priority: the lowest set req index.
- sel = winner index whenever any req bit is set, otherwise holds 0. gnt[winner] = can_load && |req. Otherwise gnt=0.
- On an edge with gnt!=0: out_data <= mux(sel), out_src <= winner, out_valid <= 1, last_ptr <= winner, next state FULL. Result is visible 1 cycle after grant.
- On an edge in FULL with out_ready=1 and req=0: out_valid <= 0, next state EMPTY. out_data and out_src keep their last value.
- In FULL with out_ready=0 (stall): out_data, out_src and last_ptr stay stable. gnt=0. Requesters keep req and data asserted.
- Simultaneous consume and load in FULL (out_ready=1, req!=0): new word replaces the old in the same edge. Throughput is 1 word/cycle.
- last_ptr updates only on a grant. In PRIO_MODE=1 last_ptr is ignored.
- A requester must hold req and data stable until it samples gnt high at a rising edge, then may drop or change both. A req drop without a grant is legal; no state is kept per requester.
- Asserting Rst_n mid-transfer discards the buffered word. Requesters must re-request after reset.
- No arithmetic on data; width is passed through unchanged.

Decomposition:
- Shared include/package holds:
  - SRC_A..SRC_D encodings (2'd0..2'd3)
  - state encodings ST_EMPTY=1'b0, ST_FULL=1'b1
  - PRIO_RR / PRIO_FIXED constants
- One natural sub-module: rr_pick4, a combinational 4-way pick from req and last_ptr with a mode input.
- The data select reuses the existing Mux32Bit4To1 driven by sel.

Test Plan:
- Reset then idle: Rst_n low 3 cycles, req=0 -> out_valid=0, out_data=0, gnt=0, sel=0 throughout.
- Single request: in_b=0x0000_00FF, req=4'b0010, out_ready=1 -> gnt=4'b0010 in cycle 0; cycle 1 out_valid=1, out_data=0x0000_00FF, out_src=1; req dropped -> out_valid=0 at cycle 2.
- Round-robin fairness: req=4'b1111 held, out_ready=1, in_a..in_d=0xA,0xB,0xC,0xD -> grants A,B,C,D,A on consecutive cycles; out_data 0xA,0xB,0xC,0xD,0xA one cycle later.
- Backpressure: FULL with out_data=0x1234_5678, out_ready=0 for 4 cycles, req=4'b0100 -> gnt=0, out_data stable; out_ready=1 -> gnt=4'b0100 that cycle, next out_data=in_c.
- Fixed priority (PRIO_MODE=1): req=4'b1010 for 3 cycles -> B granted every cycle, D never granted until req[1] drops.
- Async reset mid-operation: out_valid=1, out_data=0xDEAD_BEEF, Rst_n pulsed low between edges -> out_valid=0, out_data=0 immediately; after release, req=4'b1111 -> A granted first.

Source files
------------

// File: rtl/result_mux_arbiter_pkg.sv
// Shared encodings for the result-path arbiter.
// Source indices, output-stage states and policy selectors.
`timescale 1ns/1ps
package result_mux_arbiter_pkg;

  localparam logic [1:0] SRC_A = 2'd0;
  localparam logic [1:0] SRC_B = 2'd1;
  localparam logic [1:0] SRC_C = 2'd2;
  localparam logic [1:0] SRC_D = 2'd3;

  localparam logic PRIO_RR    = 1'b0;
  localparam logic PRIO_FIXED = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  function automatic logic [1:0] low_idx(
    input logic [3:0] v
  );
    logic [1:0] r;
    if (v[0])      r = SRC_A;
    else if (v[1]) r = SRC_B;
    else if (v[2]) r = SRC_C;
    else if (v[3]) r = SRC_D;
    else           r = SRC_A;
    return r;
  endfunction

endpackage

// File: rtl/mux32bit4to1.sv
// 4-to-1 word mux for the result path.
// Pure combinational select, width passed through.
`timescale 1ns/1ps
module Mux32Bit4To1 #(
  parameter int W = 32
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  input  logic [1:0]   sel,
  output logic [W-1:0] out
);

  always_comb begin
    out = in0;
    unique case (sel)
      2'd0: out = in0;
      2'd1: out = in1;
      2'd2: out = in2;
      2'd3: out = in3;
    endcase
  end

endmodule

// File: rtl/result_mux_arbiter_rr_pick4.sv
// Combinational 4-way winner pick.
// Round-robin after last_ptr, or lowest index first.
`timescale 1ns/1ps
module rr_pick4
  import result_mux_arbiter_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last_ptr,
  input  logic       mode,
  output logic       any,
  output logic [1:0] idx
);

  logic [1:0] base;
  logic [1:0] off;
  logic [6:0] dbl;
  logic [3:0] rot;

  // Rotate so the slot after last_ptr lands at bit 0.
  always_comb begin
    base = last_ptr + 2'd1;
    dbl  = {req[2:0], req};
    rot  = dbl[base +: 4];
    off  = low_idx(rot);
    any  = |req;
    if (mode == PRIO_FIXED) idx = low_idx(req);
    else                    idx = base + off;
  end

endmodule

// File: rtl/result_mux_arbiter.sv
// Four-source result arbiter with a registered
// single-entry valid/ready output stage.
`timescale 1ns/1ps
module result_mux_arbiter
  import result_mux_arbiter_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int PRIO_MODE = 0
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [3:0]        req,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] in_c,
  input  logic [DATA_W-1:0] in_d,
  output logic [3:0]        gnt,
  output logic [1:0]        sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_src,
  input  logic              out_ready
);

  state_t              state_q;
  state_t              state_d;
  logic [1:0]          last_q;
  logic [1:0]          win;
  logic                any;
  logic                can_load;
  logic                load;
  logic                mode;
  logic [DATA_W-1:0]   mux_out;

  assign mode = (PRIO_MODE != 0) ? PRIO_FIXED : PRIO_RR;

  rr_pick4 u_pick (
    .req      (req),
    .last_ptr (last_q),
    .mode     (mode),
    .any      (any),
    .idx      (win)
  );

  Mux32Bit4To1 #(.W(DATA_W)) u_mux (
    .in0 (in_a),
    .in1 (in_b),
    .in2 (in_c),
    .in3 (in_d),
    .sel (sel),
    .out (mux_out)
  );

  always_comb begin
    can_load = (state_q == ST_EMPTY) || out_ready;
    sel      = (Rst_n && any) ? win : 2'd0;
    gnt      = 4'b0000;
    if (Rst_n && any && can_load)
      gnt = 4'b0001 << win;
    load     = |gnt;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (load) state_d = ST_FULL;
      ST_FULL: begin
        if (load)           state_d = ST_FULL;
        else if (out_ready) state_d = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // last_q resets to D so the first scan starts at A.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      out_data <= '0;
      out_src  <= SRC_A;
      last_q   <= SRC_D;
    end else if (load) begin
      out_data <= mux_out;
      out_src  <= win;
      last_q   <= win;
    end
  end

  assign out_valid = (state_q == ST_FULL);

endmodule

// File: tb/tb_result_mux_arbiter.sv
// Randomized and directed bench for result_mux_arbiter,
// one round-robin and one fixed-priority instance.
`timescale 1ns/1ps
module tb_result_mux_arbiter;

  logic        Clk = 1'b0;
  logic        Rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;
  logic        out_ready = 1'b0;

  logic [3:0]  gnt_r, gnt_f;
  logic [1:0]  sel_r, sel_f;
  logic        ov_r, ov_f;
  logic [31:0] od_r, od_f;
  logic [1:0]  os_r, os_f;

  int n_chk = 0;
  int n_pass = 0;

  logic [3:0]  g_r, g_f;

  bit          mv [2];
  logic [31:0] md [2];
  int          ms [2];
  int          ml [2];

  always #5 Clk = ~Clk;

  result_mux_arbiter #(.DATA_W(32), .PRIO_MODE(0)) u_rr (
    .Clk(Clk), .Rst_n(Rst_n), .req(req),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .gnt(gnt_r), .sel(sel_r), .out_valid(ov_r),
    .out_data(od_r), .out_src(os_r), .out_ready(out_ready)
  );

  result_mux_arbiter #(.DATA_W(32), .PRIO_MODE(1)) u_fx (
    .Clk(Clk), .Rst_n(Rst_n), .req(req),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .gnt(gnt_f), .sel(sel_f), .out_valid(ov_f),
    .out_data(od_f), .out_src(os_f), .out_ready(out_ready)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h",
                  tag, obs, exp);
  endtask

  task automatic reset_model();
    for (int m = 0; m < 2; m++) begin
      mv[m] = 1'b0;
      md[m] = '0;
      ms[m] = 0;
      ml[m] = 3;
    end
  endtask

  function automatic int ewin(input int m,
                              input logic [3:0] r);
    int i;
    if (m == 1) begin
      for (int k = 0; k < 4; k++)
        if (r[k]) return k;
      return 0;
    end
    for (int k = 1; k <= 4; k++) begin
      i = (ml[m] + k) % 4;
      if (r[i]) return i;
    end
    return 0;
  endfunction

  task automatic step(input logic [3:0] r,
                      input logic rdy,
                      input logic [31:0] a,
                      input logic [31:0] b,
                      input logic [31:0] c,
                      input logic [31:0] d);
    logic [31:0] dv [4];
    logic [3:0]  eg [2];
    logic [1:0]  es [2];
    int          w  [2];
    @(negedge Clk);
    req = r; out_ready = rdy;
    in_a = a; in_b = b; in_c = c; in_d = d;
    dv[0] = a; dv[1] = b; dv[2] = c; dv[3] = d;
    #1;
    for (int m = 0; m < 2; m++) begin
      w[m]  = ewin(m, r);
      eg[m] = '0;
      es[m] = '0;
      if (Rst_n && r != 0) begin
        es[m] = 2'(w[m]);
        if (!mv[m] || rdy) eg[m] = 4'(1 << w[m]);
      end
    end
    g_r = gnt_r;
    g_f = gnt_f;
    chk("gnt_rr", {28'd0, gnt_r}, {28'd0, eg[0]});
    chk("sel_rr", {30'd0, sel_r}, {30'd0, es[0]});
    chk("gnt_fx", {28'd0, gnt_f}, {28'd0, eg[1]});
    chk("sel_fx", {30'd0, sel_f}, {30'd0, es[1]});
    @(posedge Clk);
    if (Rst_n) begin
      for (int m = 0; m < 2; m++) begin
        if (eg[m] != 0) begin
          mv[m] = 1'b1;
          md[m] = dv[w[m]];
          ms[m] = w[m];
          ml[m] = w[m];
        end else if (mv[m] && rdy) begin
          mv[m] = 1'b0;
        end
      end
    end
    #1;
    chk("ov_rr", {31'd0, ov_r}, {31'd0, mv[0]});
    chk("od_rr", od_r, md[0]);
    chk("os_rr", {30'd0, os_r}, 32'(ms[0]));
    chk("ov_fx", {31'd0, ov_f}, {31'd0, mv[1]});
    chk("od_fx", od_f, md[1]);
    chk("os_fx", {30'd0, os_f}, 32'(ms[1]));
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    reset_model();
    for (int k = 0; k < 3; k++) begin
      step(4'b0000, 1'b0, 32'h1, 32'h2, 32'h3, 32'h4);
      chk("rst_od", od_r, 32'd0);
    end
    @(negedge Clk);
    Rst_n = 1'b1;

    for (int k = 0; k < 5; k++) begin
      step(4'b1111, 1'b1, 32'hA, 32'hB, 32'hC, 32'hD);
      chk("rr_fair_gnt", {28'd0, g_r}, 32'(1 << (k % 4)));
      chk("rr_fair_od", od_r, 32'(10 + (k % 4)));
    end

    step(4'b0010, 1'b1, 32'h0, 32'hFF, 32'h0, 32'h0);
    chk("single_gnt", {28'd0, g_r}, 32'h2);
    chk("single_od", od_r, 32'hFF);
    chk("single_os", {30'd0, os_r}, 32'd1);
    step(4'b0000, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("single_drop", {31'd0, ov_r}, 32'd0);

    step(4'b0001, 1'b1, 32'h12345678, 32'h0, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) begin
      step(4'b0100, 1'b0, 32'h0, 32'h0, 32'h5555AAAA, 32'h0);
      chk("bp_gnt", {28'd0, g_r}, 32'd0);
      chk("bp_od", od_r, 32'h12345678);
    end
    step(4'b0100, 1'b1, 32'h0, 32'h0, 32'h5555AAAA, 32'h0);
    chk("bp_rel_gnt", {28'd0, g_r}, 32'h4);
    chk("bp_rel_od", od_r, 32'h5555AAAA);

    for (int k = 0; k < 3; k++) begin
      step(4'b1010, 1'b1, 32'h0, 32'hB0, 32'h0, 32'hD0);
      chk("fx_gnt", {28'd0, g_f}, 32'h2);
    end
    step(4'b1000, 1'b1, 32'h0, 32'hB0, 32'h0, 32'hD0);
    chk("fx_gnt_d", {28'd0, g_f}, 32'h8);

    step(4'b0001, 1'b1, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
    chk("ar_pre_od", od_r, 32'hDEADBEEF);
    @(negedge Clk);
    req = 4'b0000;
    #2 Rst_n = 1'b0;
    #1;
    chk("ar_ov_rr", {31'd0, ov_r}, 32'd0);
    chk("ar_od_rr", od_r, 32'd0);
    chk("ar_ov_fx", {31'd0, ov_f}, 32'd0);
    chk("ar_od_fx", od_f, 32'd0);
    reset_model();
    #1 Rst_n = 1'b1;
    step(4'b1111, 1'b1, 32'hA, 32'hB, 32'hC, 32'hD);
    chk("ar_first_rr", {28'd0, g_r}, 32'h1);
    chk("ar_first_fx", {28'd0, g_f}, 32'h1);

    for (int k = 0; k < 300; k++) begin
      step(4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0),
           $urandom, $urandom, $urandom, $urandom);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
